sweep_ctrl: RTL and testbench
=============================

// Module: sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the sine generator. It drives the generator's enable and phase
//  increment, stepping incr from a start to a stop value with a programmable dwell per step.
//  Single-shot or looping. Sits between the control/register layer and the sine generator.
// PARAMETERS
//  WIDTH    8   width of incr values; equals the phase counter WIDTH
//  DWELL_W  16  width of the dwell-count configuration
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  start        in   1        start request; sampled in IDLE only
//  abort        in   1        stop the sweep immediately; no done pulse
//  cfg_start    in   WIDTH    first incr value
//  cfg_stop     in   WIDTH    highest incr value allowed
//  cfg_step     in   WIDTH    incr delta per step
//  cfg_dwell    in   DWELL_W  cycles per step; 0 is treated as 1
//  cfg_loop     in   1        1: restart at cfg_start after the last step; 0: finish
//  cfg_pingpong in   1        direction reversal; used only with SWEEP_PINGPONG_EN
//  sg_en        out  1        enable to the sine generator
//  sg_incr      out  WIDTH    increment to the sine generator
//  busy         out  1        sweep in progress
//  done         out  1        1-cycle pulse at normal completion
// BEHAVIOUR
//  - All outputs are registered. Reset: sg_en=0, sg_incr=0, busy=0, done=0, state=IDLE, dwell count=0.
//  - States:
//    - IDLE: waits for start.
//    - RUN: sg_en=1, busy=1.
//    - DONE: done=1, sg_en=0, busy=0, one cycle, then IDLE.
//  - Start: start=1 in IDLE at edge N latches all cfg_* inputs. From cycle N+1: RUN, sg_incr=cfg_start.
//    - start in RUN or DONE is ignored.
//    - cfg_* changes during RUN have no effect.
//  - Dwell: each sg_incr value is held exactly max(cfg_dwell,1) cycles.
//    - On the last dwell cycle, next = sg_incr + step, computed in WIDTH+1 bits; overflow is never wrapped.
//    - If next <= stop: sg_incr <= next.
//    - Else if loop: sg_incr <= start.
//    - Else: go to DONE.
//  - Single-shot, in-range case: done asserts exactly (nsteps*dwell)+1 cycles after start is sampled.
//  - start > stop: one dwell at start, then DONE (or restart at start if loop).
//  - step = 0: sg_incr stays at start indefinitely; only abort or rst ends the sweep.
//  - Priority: rst > abort > dwell/step logic.
//    - abort in RUN: next cycle IDLE, sg_en=0, busy=0, done=0; sg_incr keeps its last value.
//    - abort in IDLE or DONE has no effect.
// CONFIGURATION
//  SWEEP_PINGPONG_EN defined, cfg_pingpong latched 1:
//    - Up phase as above. When next > stop, reverse: sg_incr <= sg_incr - step.
//    - Down phase: when sg_incr - step < start (unsigned underflow included), then:
//      - loop: reverse to up (sg_incr + step);
//      - no loop: DONE.
//    - The endpoint values are held one dwell each, not two.
//  SWEEP_PINGPONG_EN undefined:
//    - cfg_pingpong is ignored; no direction register is built. Behaviour is as in BEHAVIOUR.
// STRUCTURE
//  sweep_pkg:
//    - typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;
//    - the WIDTH and DWELL_W defaults as localparams.
//  Sub-module sweep_dwell_timer (clk, rst, load, dwell, last):
//    - down-counter reloaded at each step;
//    - 'last' flags the final dwell cycle.
// TESTING
//  1. start=10, stop=30, step=10, dwell=4, loop=0
//     -> sg_incr 10,20,30 for 4 cycles each; done pulse at cycle 13; sg_en=0 after.
//  2. Same config, loop=1
//     -> 10,20,30,10,20,... repeats; abort at cycle 7 -> sg_en=0, busy=0 next cycle, no done.
//  3. start=200, stop=255, step=60, dwell=1
//     -> one cycle at 200, then done (260 caught by the 9-bit compare, no wrap to 4).
//  4. dwell=0, start=5, stop=6, step=1 -> 5 and 6 one cycle each, then done.
//     start pulsed during RUN -> ignored; cfg_start changed mid-run -> no effect.
//  5. rst asserted mid-RUN -> next cycle all outputs 0, state IDLE; a fresh start then behaves as test 1.
//  6. With SWEEP_PINGPONG_EN, pingpong=1, start=10, stop=30, step=10, dwell=2, loop=0
//     -> 10,20,30,20,10 for 2 cycles each, then done.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and default widths for the frequency-sweep sequencer.
package sweep_pkg;
   localparam int SWEEP_WIDTH   = 8;
   localparam int SWEEP_DWELL_W = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;
endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell down-counter: reloaded at each step, 'last' marks the final cycle of the dwell.
module sweep_dwell_timer
   import sweep_pkg::*;
#(
   parameter int DWELL_W = SWEEP_DWELL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] dwell,
   output logic               last
);

   logic [DWELL_W-1:0] count;

   // A zero dwell behaves as one cycle, so both reload to zero remaining.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= (dwell == '0) ? '0 : dwell - 1'b1;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign last = (count == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer driving the sine generator's enable and phase increment.
// Optional ping-pong (up/down) sweeping is built only when SWEEP_PINGPONG_EN is defined.
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int WIDTH   = SWEEP_WIDTH,
   parameter int DWELL_W = SWEEP_DWELL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   cfg_start,
   input  logic [WIDTH-1:0]   cfg_stop,
   input  logic [WIDTH-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_loop,
   input  logic               cfg_pingpong,
   output logic               sg_en,
   output logic [WIDTH-1:0]   sg_incr,
   output logic               busy,
   output logic               done
);

   sweep_state_t       state, state_nxt;
   logic [WIDTH-1:0]   start_q, stop_q, step_q, incr_nxt;
   logic [DWELL_W-1:0] dwell_q;
   logic               loop_q;
   logic               en_nxt, busy_nxt, done_nxt;
   logic               accept, last, timer_load, stop_run;
   logic               pp_q, down_q, down_nxt;
   logic [WIDTH:0]     up_sum, dn_diff;
   logic               dn_under;

   assign accept = (state == IDLE) && start;

   // One extra bit so an overflowing sum compares above stop instead of wrapping.
   assign up_sum   = {1'b0, sg_incr} + {1'b0, step_q};
   assign dn_diff  = {1'b0, sg_incr} - {1'b0, step_q};
   assign dn_under = dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < start_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         loop_q  <= 1'b0;
      end else if (accept) begin
         start_q <= cfg_start;
         stop_q  <= cfg_stop;
         step_q  <= cfg_step;
         dwell_q <= cfg_dwell;
         loop_q  <= cfg_loop;
      end
   end

`ifdef SWEEP_PINGPONG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pp_q   <= 1'b0;
         down_q <= 1'b0;
      end else begin
         if (accept)
            pp_q <= cfg_pingpong;
         down_q <= down_nxt;
      end
   end
`else
   logic unused_pp;
   assign pp_q      = 1'b0;
   assign down_q    = 1'b0;
   assign unused_pp = ^{cfg_pingpong, down_nxt, dn_under};
`endif

   sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .dwell (accept ? cfg_dwell : dwell_q),
      .last  (last)
   );

   always_comb begin
      state_nxt  = state;
      incr_nxt   = sg_incr;
      en_nxt     = sg_en;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      down_nxt   = down_q;
      timer_load = 1'b0;
      stop_run   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = RUN;
               incr_nxt   = cfg_start;
               en_nxt     = 1'b1;
               busy_nxt   = 1'b1;
               down_nxt   = 1'b0;
               timer_load = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               en_nxt    = 1'b0;
               busy_nxt  = 1'b0;
            end else if (last) begin
               timer_load = 1'b1;
               if (pp_q && down_q) begin
                  if (!dn_under)
                     incr_nxt = dn_diff[WIDTH-1:0];
                  else if (loop_q) begin
                     down_nxt = 1'b0;
                     incr_nxt = up_sum[WIDTH-1:0];
                  end else
                     stop_run = 1'b1;
               end else if (up_sum <= {1'b0, stop_q})
                  incr_nxt = up_sum[WIDTH-1:0];
               else if (pp_q) begin
                  down_nxt = 1'b1;
                  incr_nxt = dn_diff[WIDTH-1:0];
               end else if (loop_q)
                  incr_nxt = start_q;
               else
                  stop_run = 1'b1;
               if (stop_run) begin
                  state_nxt = DONE;
                  en_nxt    = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sg_en   <= 1'b0;
         sg_incr <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         sg_en   <= en_nxt;
         sg_incr <= incr_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: queue-based per-cycle reference model, directed literal cases, random sweeps.
module tb_sweep_ctrl;
   localparam int W  = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst, start, abort, cfg_loop, cfg_pingpong;
   logic [W-1:0]  cfg_start, cfg_stop, cfg_step;
   logic [DW-1:0] cfg_dwell;
   logic          sg_en, busy, done;
   logic [W-1:0]  sg_incr;

   int vectors = 0;
   int miscompares = 0;

   sweep_ctrl #(.WIDTH(W), .DWELL_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
      .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .cfg_pingpong(cfg_pingpong),
      .sg_en(sg_en), .sg_incr(sg_incr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: a queue holds the sg_incr value for every remaining cycle of the current dwell.
   int  q[$];
   int  m_start, m_stop, m_stp, m_dw, m_cur;
   bit  m_run, m_loop, m_pp, m_down;
   bit  e_en, e_busy, e_done;
   int  e_incr;
   bit  chk_on = 0;

   function automatic void m_advance();
      int nv  = 0;
      bit fin = 0;
      if (m_pp && m_down) begin
         if (m_cur - m_stp >= m_start) nv = m_cur - m_stp;
         else if (m_loop) begin m_down = 0; nv = m_cur + m_stp; end
         else fin = 1;
      end else if (m_cur + m_stp <= m_stop) nv = m_cur + m_stp;
      else if (m_pp) begin m_down = 1; nv = m_cur - m_stp; end
      else if (m_loop) nv = m_start;
      else fin = 1;
      if (fin) begin
         m_run = 0; e_en = 0; e_busy = 0; e_done = 1;
      end else begin
         m_cur = nv & ((1 << W) - 1);
         repeat (m_dw) q.push_back(m_cur);
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; q.delete();
         e_en = 0; e_busy = 0; e_done = 0; e_incr = 0;
      end else if (m_run) begin
         if (abort) begin
            m_run = 0; q.delete(); e_en = 0; e_busy = 0;
         end else begin
            if (q.size() == 0) m_advance();
            if (m_run) e_incr = q.pop_front();
         end
      end else if (e_done) begin
         e_done = 0;
      end else if (start) begin
         m_start = cfg_start; m_stop = cfg_stop; m_stp = cfg_step;
         m_dw    = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
         m_loop  = cfg_loop;
`ifdef SWEEP_PINGPONG_EN
         m_pp    = cfg_pingpong;
`else
         m_pp    = 0;
`endif
         m_down = 0; m_cur = m_start; q.delete();
         repeat (m_dw) q.push_back(m_start);
         e_incr = q.pop_front();
         e_en = 1; e_busy = 1; m_run = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("sg_en",   {31'b0, sg_en},  {31'b0, e_en});
         chk("busy",    {31'b0, busy},   {31'b0, e_busy});
         chk("done",    {31'b0, done},   {31'b0, e_done});
         chk("sg_incr", {24'b0, sg_incr}, 32'(e_incr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int s, input int p, input int st, input int d, input bit lp, input bit pp);
      cfg_start = W'(s); cfg_stop = W'(p); cfg_step = W'(st);
      cfg_dwell = DW'(d); cfg_loop = lp; cfg_pingpong = pp;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

`ifdef SWEEP_PINGPONG_EN
   int pp_exp[5] = '{10, 20, 30, 20, 10};
`endif

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      tick();
      chk_on = 1;
      tick();
      chk("rst_en", {31'b0, sg_en}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_incr", {24'b0, sg_incr}, 32'd0);
      rst = 1'b0;
      tick();

      // single shot 10..30 step 10 dwell 4: done 13 cycles after start is sampled
      set_cfg(10, 30, 10, 4, 0, 0);
      do_start();
      for (int i = 0; i < 12; i++) begin
         chk("t1_incr", {24'b0, sg_incr}, 32'(10 + 10 * (i / 4)));
         chk("t1_en", {31'b0, sg_en}, 32'd1);
         tick();
      end
      chk("t1_done", {31'b0, done}, 32'd1);
      chk("t1_en_off", {31'b0, sg_en}, 32'd0);
      tick();
      chk("t1_done_pulse", {31'b0, done}, 32'd0);
      tick();

      // looping, aborted in cycle 7
      set_cfg(10, 30, 10, 4, 1, 0);
      do_start();
      repeat (6) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t2_en", {31'b0, sg_en}, 32'd0);
      chk("t2_busy", {31'b0, busy}, 32'd0);
      chk("t2_done", {31'b0, done}, 32'd0);
      chk("t2_incr_kept", {24'b0, sg_incr}, 32'd20);
      repeat (6) tick();

      // overflow past 255 must not wrap
      set_cfg(200, 255, 60, 1, 0, 0);
      do_start();
      chk("t3_incr", {24'b0, sg_incr}, 32'd200);
      tick();
      chk("t3_done", {31'b0, done}, 32'd1);
      repeat (2) tick();

      // dwell 0 as 1; start and cfg changes mid-run ignored
      set_cfg(5, 6, 1, 0, 0, 0);
      do_start();
      chk("t4_incr0", {24'b0, sg_incr}, 32'd5);
      cfg_start = 8'd99;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_incr1", {24'b0, sg_incr}, 32'd6);
      tick();
      chk("t4_done", {31'b0, done}, 32'd1);
      repeat (2) tick();

      // reset mid-run, then a fresh sweep
      set_cfg(10, 30, 10, 4, 0, 0);
      do_start();
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_en", {31'b0, sg_en}, 32'd0);
      chk("t5_busy", {31'b0, busy}, 32'd0);
      chk("t5_incr", {24'b0, sg_incr}, 32'd0);
      do_start();
      repeat (14) tick();

`ifdef SWEEP_PINGPONG_EN
      set_cfg(10, 30, 10, 2, 0, 1);
      do_start();
      for (int i = 0; i < 10; i++) begin
         chk("t6_incr", {24'b0, sg_incr}, 32'(pp_exp[i / 2]));
         tick();
      end
      chk("t6_done", {31'b0, done}, 32'd1);
      repeat (2) tick();
`endif

      // random sweeps with stray starts, aborts and cfg churn
      for (int t = 0; t < 60; t++) begin
         n = int'($urandom_range(0, 200));
         set_cfg(n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : n + int'($urandom_range(0, 55)),
                 int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         do_start();
         n = int'($urandom_range(1, 50));
         repeat (n) begin
            abort = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 7) == 0);
            cfg_start = W'($urandom_range(0, 255));
            tick();
            abort = 1'b0;
            start = 1'b0;
         end
         abort = 1'b1;
         tick();
         abort = 1'b0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
